// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: datapath width, register-file geometry and write-back select encoding.
package pipeline_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREG  = 32;
   localparam int unsigned IDX_W = 5;

   localparam logic [IDX_W-1:0] REG_ZERO = 5'd0;

   // Reg2reg select encoding shared by write-back and forwarding muxes
   localparam logic SEL_ALU = 1'b1;
   localparam logic SEL_MEM = 1'b0;

endpackage

// File: rtl/wb_select.sv
// Write-back source mux: ALU result or load data; also reused by the forwarding unit.
module wb_select
   import pipeline_pkg::*;
#(
   parameter int unsigned W = pipeline_pkg::XLEN
) (
   input  logic         sel,
   input  logic [W-1:0] alu,
   input  logic [W-1:0] mem,
   output logic [W-1:0] y_c
);

   always_comb begin
      y_c = mem;
      if (sel == SEL_ALU) begin
         y_c = alu;
      end
   end

endmodule

// File: rtl/pipelined_wb_regfile.sv
// Write-back stage plus architectural register file with two combinational read
// ports and an optional same-cycle write-to-read bypass; r0 is hardwired to zero.
module pipelined_wb_regfile
   import pipeline_pkg::*;
#(
   parameter int unsigned XLEN      = pipeline_pkg::XLEN,
   parameter int unsigned NREG      = pipeline_pkg::NREG,
   parameter bit          BYPASS_EN = 1'b1
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             WB_Wreg,
   input  logic             WB_Reg2reg,
   input  logic [XLEN-1:0]  WB_Date_out,
   input  logic [XLEN-1:0]  WB_Alu,
   input  logic [IDX_W-1:0] WB_write_reg,
   input  logic [IDX_W-1:0] ID_rs,
   input  logic [IDX_W-1:0] ID_rt,
   output logic [XLEN-1:0]  ID_Qa,
   output logic [XLEN-1:0]  ID_Qb,
   output logic [XLEN-1:0]  WB_wdata,
   output logic             WB_commit
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic            commit_q;
   logic            commit_d;
   logic [XLEN-1:0] wdata_c;
   logic            wr_en_c;

   wb_select #(.W(XLEN)) u_wb_select (
      .sel (WB_Reg2reg),
      .alu (WB_Alu),
      .mem (WB_Date_out),
      .y_c (wdata_c)
   );

   assign WB_wdata = wdata_c;

   // Reset takes priority, so a write in a clearing cycle is neither committed nor bypassed
   assign wr_en_c = !Clr && WB_Wreg && (WB_write_reg != REG_ZERO);

   always_comb begin
      regs_d   = regs_q;
      commit_d = wr_en_c;
      if (wr_en_c) begin
         regs_d[WB_write_reg] = wdata_c;
      end
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         regs_q   <= '{default: '0};
         commit_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         commit_q <= commit_d;
      end
   end

   assign WB_commit = commit_q;

   always_comb begin
      ID_Qa = regs_q[ID_rs];
      if (ID_rs == REG_ZERO) begin
         ID_Qa = '0;
      end else if (BYPASS_EN && wr_en_c && (WB_write_reg == ID_rs)) begin
         ID_Qa = wdata_c;
      end
   end

   always_comb begin
      ID_Qb = regs_q[ID_rt];
      if (ID_rt == REG_ZERO) begin
         ID_Qb = '0;
      end else if (BYPASS_EN && wr_en_c && (WB_write_reg == ID_rt)) begin
         ID_Qb = wdata_c;
      end
   end

endmodule

// File: tb/tb_pipelined_wb_regfile.sv
// Self-checking bench: a bypassing and a non-bypassing register file share stimulus and
// are compared each cycle against an array model, plus hand-computed directed expectations.
module tb_pipelined_wb_regfile;

   logic        Clk = 1'b0;
   logic        Clr;
   logic        WB_Wreg;
   logic        WB_Reg2reg;
   logic [31:0] WB_Date_out;
   logic [31:0] WB_Alu;
   logic [4:0]  WB_write_reg;
   logic [4:0]  ID_rs;
   logic [4:0]  ID_rt;
   logic [31:0] qa_b, qb_b, wd_b, qa_n, qb_n, wd_n;
   logic        cm_b, cm_n;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   pipelined_wb_regfile #(.XLEN(32), .NREG(32), .BYPASS_EN(1'b1)) dut_b (
      .Clk(Clk), .Clr(Clr), .WB_Wreg(WB_Wreg), .WB_Reg2reg(WB_Reg2reg),
      .WB_Date_out(WB_Date_out), .WB_Alu(WB_Alu), .WB_write_reg(WB_write_reg),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_Qa(qa_b), .ID_Qb(qb_b),
      .WB_wdata(wd_b), .WB_commit(cm_b)
   );

   pipelined_wb_regfile #(.XLEN(32), .NREG(32), .BYPASS_EN(1'b0)) dut_n (
      .Clk(Clk), .Clr(Clr), .WB_Wreg(WB_Wreg), .WB_Reg2reg(WB_Reg2reg),
      .WB_Date_out(WB_Date_out), .WB_Alu(WB_Alu), .WB_write_reg(WB_write_reg),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_Qa(qa_n), .ID_Qb(qb_n),
      .WB_wdata(wd_n), .WB_commit(cm_n)
   );

   // Architectural model: register contents and the expected commit pulse
   logic [31:0] mdl [32];
   logic        mdl_commit = 1'b0;
   bit          mdl_valid  = 1'b0;

   function automatic logic [31:0] sel_val();
      return WB_Reg2reg ? WB_Alu : WB_Date_out;
   endfunction

   function automatic bit writing();
      return !Clr && WB_Wreg && (WB_write_reg != 5'd0);
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit byp);
      if (idx == 5'd0) return 32'h0;
      if (byp && writing() && WB_write_reg == idx) return sel_val();
      return mdl[idx];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge Clk) begin
      if (Clr) begin
         for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
         mdl_commit = 1'b0;
         mdl_valid  = 1'b1;
      end else begin
         mdl_commit = writing();
         if (writing()) mdl[WB_write_reg] = sel_val();
      end
   end

   always @(negedge Clk) begin
      if (mdl_valid) begin
         chk("wdata_b",  wd_b, sel_val());
         chk("wdata_n",  wd_n, sel_val());
         chk("qa_byp",   qa_b, exp_read(ID_rs, 1'b1));
         chk("qb_byp",   qb_b, exp_read(ID_rt, 1'b1));
         chk("qa_nobyp", qa_n, exp_read(ID_rs, 1'b0));
         chk("qb_nobyp", qb_n, exp_read(ID_rt, 1'b0));
         chk("commit_b", 32'(cm_b), 32'(mdl_commit));
         chk("commit_n", 32'(cm_n), 32'(mdl_commit));
      end
   end

   // Apply one cycle of inputs just after the rising edge
   task automatic drive(input logic clr, input logic wreg, input logic r2r,
                        input logic [31:0] dout, input logic [31:0] alu,
                        input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt);
      @(posedge Clk);
      #1;
      Clr = clr; WB_Wreg = wreg; WB_Reg2reg = r2r; WB_Date_out = dout;
      WB_Alu = alu; WB_write_reg = dest; ID_rs = rs; ID_rt = rt;
      #2;
   endtask

   initial begin
      Clr = 1'b1; WB_Wreg = 1'b1; WB_Reg2reg = 1'b1; WB_Date_out = 32'h0;
      WB_Alu = 32'hDEADBEEF; WB_write_reg = 5'd5; ID_rs = 5'd5; ID_rt = 5'd5;

      // Reset with a concurrent write to r5
      drive(1, 1, 1, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
      drive(0, 0, 1, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
      chk("lit_reset_r5", qa_b, 32'h0);
      chk("lit_reset_commit", 32'(cm_b), 32'h0);

      // ALU write to r3 with same-cycle read
      drive(0, 1, 1, 32'h0, 32'h12345678, 5'd3, 5'd3, 5'd0);
      chk("lit_r3_bypass", qa_b, 32'h12345678);
      chk("lit_r3_nobypass_old", qa_n, 32'h0);
      drive(0, 0, 1, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
      chk("lit_r3_stored", qa_b, 32'h12345678);
      chk("lit_r3_stored_n", qa_n, 32'h12345678);
      chk("lit_r3_commit", 32'(cm_b), 32'h1);
      drive(0, 0, 1, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
      chk("lit_commit_pulse_end", 32'(cm_b), 32'h0);

      // Load write to r31
      drive(0, 1, 0, 32'h0000ABCD, 32'hFFFFFFFF, 5'd31, 5'd31, 5'd0);
      chk("lit_load_wdata", wd_b, 32'h0000ABCD);
      drive(0, 0, 0, 32'h0, 32'h0, 5'd31, 5'd31, 5'd0);
      chk("lit_r31", qa_n, 32'h0000ABCD);
      chk("lit_r31_commit", 32'(cm_n), 32'h1);

      // r0 is never written
      drive(0, 1, 1, 32'h0, 32'h55, 5'd0, 5'd0, 5'd0);
      chk("lit_r0_same_a", qa_b, 32'h0);
      chk("lit_r0_same_b", qb_b, 32'h0);
      drive(0, 0, 1, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      chk("lit_r0_next", qa_b, 32'h0);
      chk("lit_r0_commit", 32'(cm_b), 32'h0);

      // Dual read of r7 while it is overwritten
      drive(0, 1, 1, 32'h0, 32'h11111111, 5'd7, 5'd0, 5'd0);
      drive(0, 1, 1, 32'h0, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7);
      chk("lit_r7_qa_byp", qa_b, 32'hA5A5A5A5);
      chk("lit_r7_qb_byp", qb_b, 32'hA5A5A5A5);
      chk("lit_r7_qa_old", qa_n, 32'h11111111);
      chk("lit_r7_qb_old", qb_n, 32'h11111111);
      drive(0, 0, 1, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
      chk("lit_r7_qa_new", qa_n, 32'hA5A5A5A5);
      chk("lit_r7_qb_new", qb_n, 32'hA5A5A5A5);

      // Disabled write leaves r9 untouched
      drive(0, 0, 1, 32'h0, 32'h99, 5'd9, 5'd9, 5'd9);
      chk("lit_r9_same", qa_b, 32'h0);
      drive(0, 0, 1, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
      chk("lit_r9_next", qa_b, 32'h0);
      chk("lit_r9_commit", 32'(cm_b), 32'h0);

      // Mid-operation reset: stored contents visible, no bypass, then cleared
      drive(1, 1, 1, 32'h0, 32'h77, 5'd3, 5'd3, 5'd31);
      chk("lit_clr_qa_stored", qa_b, 32'h12345678);
      chk("lit_clr_qb_stored", qb_b, 32'h0000ABCD);
      drive(0, 0, 1, 32'h0, 32'h0, 5'd3, 5'd3, 5'd31);
      chk("lit_after_clr_qa", qa_b, 32'h0);
      chk("lit_after_clr_qb", qb_n, 32'h0);
      chk("lit_after_clr_commit", 32'(cm_b), 32'h0);

      // Randomised traffic, checked by the model every cycle
      for (int i = 0; i < 300; i++) begin
         logic [4:0] d;
         d = 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom),
               $urandom, $urandom, d,
               ($urandom_range(0, 2) == 0) ? d : 5'($urandom),
               ($urandom_range(0, 2) == 0) ? d : 5'($urandom));
      end

      @(posedge Clk);
      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_wb_regfile.md
Name: pipelined_wb_regfile

Overview:
- Write-back stage and architectural register file of the 5-stage pipelined CPU; it is the consumer end of the MEM/WB pipeline register.
- Selects the write-back value from memory data or the ALU result, and commits it to a 32x32 register file on the rising clock edge.
- Serves the ID stage with two combinational read ports that include a same-cycle WB->ID bypass, so there is no structural write/read hazard.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of registers and write-back paths.
- NREG, 32, number of architectural registers (index width = log2(NREG) = 5).
- BYPASS_EN, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = read returns the stored value only.

Ports:
- Clk  input  1  system clock, rising edge.
- Clr  input  1  synchronous reset, active-high.
- WB_Wreg  input  1  write enable from the MEM/WB register.
- WB_Reg2reg  input  1  write-back source select: 1 = WB_Alu, 0 = WB_Date_out (load data).
- WB_Date_out  input  XLEN  memory read data.
- WB_Alu  input  XLEN  ALU result.
- WB_write_reg  input  5  destination register index.
- ID_rs  input  5  read port A index.
- ID_rt  input  5  read port B index.
- ID_Qa  output  XLEN  read port A data.
- ID_Qb  output  XLEN  read port B data.
- WB_wdata  output  XLEN  selected write-back value, for EX/MEM forwarding muxes.
- WB_commit  output  1  registered pulse: a nonzero-index write committed on the previous edge.

Behaviour:
- Reset is synchronous and active-high, on Clk: at a rising Clk edge with Clr=1, all NREG registers clear to 0 and WB_commit clears to 0. A write presented in the same cycle is discarded.
- Reset mid-operation: the first edge with Clr=1 wins over any write. Reads after that edge return 0.
- WB_wdata = WB_Reg2reg ? WB_Alu : WB_Date_out. This path is purely combinational, with zero latency.
- Write condition: Clr=0 and WB_Wreg=1 and WB_write_reg != 0. When it holds, regs[WB_write_reg] <= WB_wdata at the rising edge.
- Writes to index 0 are ignored. regs[0] always reads 0.
- Read A, combinational:
  - ID_rs == 0 -> 0.
  - Else, if BYPASS_EN and the write condition holds and WB_write_reg == ID_rs -> WB_wdata.
  - Else -> regs[ID_rs].
- Read B: identical to read A, using ID_rt.
- When ID_rs == ID_rt, both ports return the same value, and both are bypassed if applicable.
- The bypass is gated by Clr: while Clr=1, reads return stored (pre-clear) contents, with no bypass.
- WB_commit <= (write condition), registered one cycle after the write.
- With BYPASS_EN=0, a read of the register being written returns the old value in that cycle and the new value from the next cycle onward.
- X-safety: when WB_Wreg=0, the data inputs are don't-care and must not alter state.

Decomposition:
- Shared package pipeline_pkg holds:
  - XLEN and NREG constants;
  - REG_ZERO = 5'd0;
  - the encoding constant for the Reg2reg select (SEL_ALU = 1, SEL_MEM = 0).
- One sub-module, wb_select: the two-input XLEN write-back mux driven by WB_Reg2reg. It is reused by the forwarding unit.
- The storage array and read/bypass logic stay in the top module.

Test Plan:
- Reset: assert Clr for 1 edge with WB_Wreg=1, WB_write_reg=5, WB_Alu=0xDEADBEEF -> after the edge, reading r5 returns 0 and WB_commit=0.
- ALU write then read: Reg2reg=1, Alu=0x12345678, dest=3 -> with ID_rs=3 in the same cycle, ID_Qa=0x12345678 (bypass); next cycle with WB_Wreg=0, still 0x12345678; WB_commit=1 for one cycle.
- Load write: Reg2reg=0, Date_out=0x0000ABCD, Alu=0xFFFFFFFF, dest=31 -> r31=0x0000ABCD and WB_wdata=0x0000ABCD.
- r0 protection: WB_Wreg=1, dest=0, Alu=0x55 -> ID_rs=0 reads 0 in the same and next cycles; WB_commit stays 0.
- Dual port, same index: ID_rs=ID_rt=7 with a write of 0xA5A5A5A5 to r7 -> ID_Qa and ID_Qb both 0xA5A5A5A5 in the same cycle. Repeat with BYPASS_EN=0 -> old value, then new value next cycle.
- Disabled write: WB_Wreg=0, dest=9, Alu=0x99 -> r9 unchanged, WB_commit=0.
